uart_rx_engine: RTL

Receive half of the UART. It deserialises the asynchronous `rx` line into 7- or 8-bit characters with optional odd/even parity. It reports parity, framing and overrun errors, and holds each character until the host acknowledges it. It pairs with the transmit path, which sends LSB-first frames of the form start(0), data, optional parity, stop(1), and shares the same baud configuration.

---
 rtl/uart_rx_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling of 7/8-bit frames with optional parity.
// Holds one character with parity/framing/overrun flags until acknowledged by rd_ack.
module uart_rx_engine #(
    parameter int BIT_TIME = 10416,
    parameter int CW       = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rxrdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_DONE
    } state_e;

    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_TIME / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TIME - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;
    logic          eight_q, eight_d;
    logic          pen_q, pen_d;
    logic          ohel_q, ohel_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rxrdy_q, rxrdy_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;
    logic          rx_s1_q, rx_sync_q, rx_prev_q;

    logic [3:0]    n_bits;
    logic [3:0]    d_bits;
    logic [9:0]    frame;
    logic [7:0]    data_dec;
    logic          par_bit;
    logic          stop_bit;
    logic          exp_par;

    // Frame geometry comes from the configuration latched at the start edge.
    always_comb begin
        n_bits   = 4'd8 + {3'b000, eight_q} + {3'b000, pen_q};
        d_bits   = eight_q ? 4'd8 : 4'd7;
        frame    = shift_q >> (4'd10 - n_bits);
        data_dec = eight_q ? frame[7:0] : {1'b0, frame[6:0]};
        par_bit  = frame[d_bits];
        stop_bit = frame[n_bits - 4'd1];
        exp_par  = (^data_dec) ^ ohel_q;
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        eight_d   = eight_q;
        pen_d     = pen_q;
        ohel_d    = ohel_q;
        rx_data_d = rx_data_q;
        rxrdy_d   = rxrdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;

        if (rd_ack && state_q != S_DONE) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = S_START;
                    eight_d = eight;
                    pen_d   = pen;
                    ohel_d  = ohel;
                end
            end
            S_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_sync_q, shift_q[9:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == n_bits - 4'd1) begin
                        state_d = S_DONE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                rx_data_d = data_dec;
                perr_d    = pen_q & (par_bit != exp_par);
                ferr_d    = ~stop_bit;
                rxrdy_d   = 1'b1;
                // A same-cycle ack consumes the old character, so no overrun.
                ovf_d     = ~rd_ack & (ovf_q | rxrdy_q);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= 10'h3FF;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            rx_data_q <= 8'h00;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rx_s1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            eight_q   <= eight_d;
            pen_q     <= pen_d;
            ohel_q    <= ohel_d;
            rx_data_q <= rx_data_d;
            rxrdy_q   <= rxrdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
            rx_s1_q   <= rx;
            rx_sync_q <= rx_s1_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_data = rx_data_q;
    assign rxrdy   = rxrdy_q;
    assign perr    = perr_q;
    assign ferr    = ferr_q;
    assign ovf     = ovf_q;

endmodule
